// File: rtl/nibble_demux_pkg.sv
// Shared types and defaults for the 1-to-2 nibble stream demultiplexer.
package demux_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_t;

  typedef enum logic {EMPTY, FULL} slot_state_t;

endpackage

// File: rtl/nibble_demux_if.sv
// Producer-side and consumer-side stream signals of the nibble demux.
interface nibble_demux_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic [CNT_W-1:0] a_count;
   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;
   logic [CNT_W-1:0] b_count;

   modport slave (
      input  in_data, in_sel, in_valid, a_ready, b_ready,
      output in_ready, a_data, a_valid, a_count, b_data, b_valid, b_count
   );

   modport master (
      output in_data, in_sel, in_valid, a_ready, b_ready,
      input  in_ready, a_data, a_valid, a_count, b_data, b_valid, b_count
   );
endinterface

// File: rtl/nibble_demux_slot.sv
// One-entry output slot with valid/ready handshake and a wrapping drain counter.
module demux_slot
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_count,
   output logic             o_can_accept
);

   slot_state_t      r_state;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_count;
   logic             w_drain;

   assign o_valid      = (r_state == FULL);
   assign o_data       = r_data;
   assign o_count      = r_count;
   assign w_drain      = o_valid & i_ready;
   assign o_can_accept = ~o_valid | i_ready;

   // A load while FULL only happens alongside a drain, so the slot stays FULL.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= EMPTY;
         r_data  <= '0;
         r_count <= '0;
      end else begin
         if (i_load) begin
            r_state <= FULL;
            r_data  <= i_data;
         end else if (w_drain) begin
            r_state <= EMPTY;
         end
         if (w_drain) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/nibble_demux.sv
// Registered 1-to-2 stream demux: steers tagged input words into slot a or b.
module nibble_demux
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned CNT_W = 8
) (
   input logic           clk,
   input logic           reset,
   nibble_demux_if.slave bus
);

   logic w_sel_b;
   logic w_a_can_accept;
   logic w_b_can_accept;
   logic w_fire;
   logic w_load_a;
   logic w_load_b;

   assign w_sel_b      = (sel_t'(bus.in_sel) == SEL_B);
   // Only the selected slot gates the input; the other never blocks.
   assign bus.in_ready = w_sel_b ? w_b_can_accept : w_a_can_accept;
   assign w_fire       = bus.in_valid & bus.in_ready;
   assign w_load_a     = w_fire & ~w_sel_b;
   assign w_load_b     = w_fire & w_sel_b;

   demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot_a (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_load_a),
      .i_data       (bus.in_data),
      .i_ready      (bus.a_ready),
      .o_data       (bus.a_data),
      .o_valid      (bus.a_valid),
      .o_count      (bus.a_count),
      .o_can_accept (w_a_can_accept)
   );

   demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot_b (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_load_b),
      .i_data       (bus.in_data),
      .i_ready      (bus.b_ready),
      .o_data       (bus.b_data),
      .o_valid      (bus.b_valid),
      .o_count      (bus.b_count),
      .o_can_accept (w_b_can_accept)
   );

endmodule

// File: tb/tb_nibble_demux.sv
// Scoreboard bench for nibble_demux: directed plan items plus randomized traffic.
module tb_nibble_demux;

   logic clk = 1'b0;
   logic reset = 1'b1;

   nibble_demux_if #(.WIDTH(4), .CNT_W(8)) bus ();

   nibble_demux #(
      .WIDTH (4),
      .CNT_W (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Words accepted but not yet drained, per output, in arrival order.
   logic [3:0] exp_a[$];
   logic [3:0] exp_b[$];
   int         cnt_a = 0;
   int         cnt_b = 0;

   // Word accepted this cycle; enters its queue once the edge has loaded it.
   logic       pend_v = 1'b0;
   logic       pend_sel = 1'b0;
   logic [3:0] pend_d = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic sel, input logic [3:0] d,
                        input logic ar, input logic br);
      logic exp_rdy;
      @(posedge clk);
      #1;
      if (pend_v) begin
         if (pend_sel) exp_b.push_back(pend_d);
         else          exp_a.push_back(pend_d);
         pend_v = 1'b0;
      end
      bus.in_valid = v;
      bus.in_sel   = sel;
      bus.in_data  = d;
      bus.a_ready  = ar;
      bus.b_ready  = br;
      #2;
      exp_rdy = 1'b0;
      if (!$isunknown(sel)) begin
         exp_rdy = sel ? (exp_b.size() == 0 || br) : (exp_a.size() == 0 || ar);
         check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      end
      if (v && exp_rdy) begin
         pend_v   = 1'b1;
         pend_sel = sel;
         pend_d   = d;
      end
   endtask

   // Monitor: compares slot outputs against the scoreboard once per cycle.
   always @(negedge clk) begin
      if (!reset) begin
         check("a_valid", 32'(bus.a_valid), 32'(exp_a.size() != 0));
         check("b_valid", 32'(bus.b_valid), 32'(exp_b.size() != 0));
         check("a_count", 32'(bus.a_count), 32'(cnt_a % 256));
         check("b_count", 32'(bus.b_count), 32'(cnt_b % 256));
         if (bus.a_valid && exp_a.size() != 0) begin
            check("a_data", 32'(bus.a_data), 32'(exp_a[0]));
            if (bus.a_ready) begin
               void'(exp_a.pop_front());
               cnt_a++;
            end
         end
         if (bus.b_valid && exp_b.size() != 0) begin
            check("b_data", 32'(bus.b_data), 32'(exp_b[0]));
            if (bus.b_ready) begin
               void'(exp_b.pop_front());
               cnt_b++;
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
   endtask

   initial begin
      int wrap_start;
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      bus.in_data  = '0;
      bus.a_ready  = 1'b0;
      bus.b_ready  = 1'b0;

      #1;
      check("rst_a_valid", 32'(bus.a_valid), 32'd0);
      check("rst_b_valid", 32'(bus.b_valid), 32'd0);
      check("rst_a_data", 32'(bus.a_data), 32'd0);
      check("rst_b_data", 32'(bus.b_data), 32'd0);
      check("rst_a_count", 32'(bus.a_count), 32'd0);
      check("rst_b_count", 32'(bus.b_count), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #11 reset = 1'b0;

      // First word right after reset release.
      drive(1'b1, 1'b0, 4'hF, 1'b1, 1'b1);
      idle(2);

      // Steering, one word per cycle.
      drive(1'b1, 1'b1, 4'h8, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 4'h7, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 4'hD, 1'b1, 1'b1);
      idle(2);

      // Backpressure on a while b keeps flowing.
      drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 4'h5, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 4'h9, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 4'h5, 1'b1, 1'b1);
      idle(2);

      // Simultaneous drain and load on a.
      drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 4'h2, 1'b1, 1'b1);
      idle(2);

      // Unknown select with valid low must not load anything.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'bx, 4'hE, 1'b0, 1'b0);
      idle(1);

      for (int i = 0; i < 1500; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      end
      idle(3);

      // Counter wrap: 256 drains on b bring b_count back to its start value.
      wrap_start = cnt_b % 256;
      for (int i = 0; i < 256; i++) drive(1'b1, 1'b1, 4'($urandom), 1'b1, 1'b1);
      idle(2);
      check("b_count_wrap", 32'(bus.b_count), 32'(wrap_start));

      // Mid-operation asynchronous reset with both slots full.
      drive(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 4'hB, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      check("pre_rst_a_data", 32'(bus.a_data), 32'hA);
      check("pre_rst_b_data", 32'(bus.b_data), 32'hB);
      #1;
      reset = 1'b1;
      exp_a.delete();
      exp_b.delete();
      pend_v = 1'b0;
      cnt_a  = 0;
      cnt_b  = 0;
      #1;
      check("mid_rst_a_valid", 32'(bus.a_valid), 32'd0);
      check("mid_rst_b_valid", 32'(bus.b_valid), 32'd0);
      check("mid_rst_a_data", 32'(bus.a_data), 32'd0);
      check("mid_rst_b_data", 32'(bus.b_data), 32'd0);
      check("mid_rst_a_count", 32'(bus.a_count), 32'd0);
      check("mid_rst_b_count", 32'(bus.b_count), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      #3 reset = 1'b0;

      drive(1'b1, 1'b1, 4'h6, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 4'hC, 1'b1, 1'b1);
      idle(4);
      check("drained", 32'(exp_a.size() + exp_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
